axis_uart_rx_wrapper: RTL and testbench
=======================================

Name: axis_uart_rx_wrapper

Overview:
- UART receiver: serial line in, AXI-Stream bytes out. 8N1 format, LSB first.
- Sits directly downstream of the serial line driven by axis_uart_tx_wrapper, and upstream of loopback/command logic.
- Contains a 2-flop input synchroniser, a mid-bit sampling FSM, and a 2^RX_SIZE-deep byte FIFO that decouples line timing from consumer back-pressure.
- Reports framing errors and overflow as one-cycle pulses.

Parameters:
- RX_SIZE, 4: log2 of FIFO depth in bytes (4 gives 16 entries); legal range 1..8.
- clkdiv_rx, 50: CLOCK cycles per bit; minimum 8.

Ports:
- CLOCK  in  1  system clock; all logic on the rising edge.
- RESET_N  in  1  asynchronous reset, active-low.
- rx  in  1  serial input, asynchronous to CLOCK, idles high.
- o_tdata  out  8  received byte at the FIFO head.
- o_tvalid  out  1  FIFO not empty.
- o_tready  in  1  consumer ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overflow  out  1  one-cycle pulse: byte dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release):
  - Both synchroniser flops = 1; FSM = IDLE; FIFO empty.
  - All outputs 0; o_tdata = 8'h00.
- Synchroniser: rx_s is rx delayed by 2 flops. The FSM uses only rx_s.
- Bit counter cnt is $clog2(clkdiv_rx) bits wide. Bit index runs 0..7.
- FSM:
  - IDLE: on rx_s = 0, load cnt = clkdiv_rx/2 - 1 and go to START.
  - START: decrement cnt; at 0, sample rx_s.
    - rx_s = 0: load cnt = clkdiv_rx - 1, clear bit index, go to DATA.
    - rx_s = 1: glitch; return to IDLE with no output.
  - DATA: at each cnt = 0, shift rx_s into shreg[7] (right shift, LSB first) and reload cnt. After bit 7, go to STOP.
  - STOP: at cnt = 0, sample the stop bit.
    - rx_s = 1: push the byte into the FIFO (or drop it, see overflow below); go to IDLE.
    - rx_s = 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s = 1, then go to IDLE. A held-low line produces exactly one frame_err.
- Sampling point is mid-bit: the start bit is sampled clkdiv_rx/2 cycles after the falling edge is seen on rx_s.
- FIFO:
  - Registered write/read pointers, RX_SIZE+1 bits each; full/empty come from the MSB compare.
  - Write when STOP accepts a byte.
  - Read when o_tvalid && o_tready.
  - o_tdata is the head entry, valid whenever o_tvalid = 1.
  - o_tvalid rises the cycle after the write into an empty FIFO.
  - Latency from stop-bit sample to o_tvalid = 1 cycle.
- Full boundary: a write while full with no read in the same cycle drops the new byte (FIFO contents unchanged) and pulses overflow.
- Write and read in the same cycle while full: both succeed; count unchanged; no overflow.
- Write and read in the same cycle while empty cannot occur, because o_tvalid = 0.
- Pointers wrap modulo 2^(RX_SIZE+1).
- AXIS rules:
  - o_tdata and o_tvalid are held stable while o_tvalid && !o_tready.
  - o_tvalid never depends combinationally on o_tready.
- Reset mid-frame: the partial byte is lost and the FSM returns to IDLE. After release, if rx_s is still low, the FSM starts a new frame from that low level.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the frame is 8E1. A PARITY state sits between DATA and STOP and samples one extra bit.
  - Mismatch with even parity of the data byte: byte discarded at STOP, and the parity_err output (1 bit, one-cycle pulse, reset 0) pulses in the STOP cycle.
  - Mismatch together with a low stop bit: frame_err takes precedence and parity_err stays 0.
- Undefined: no PARITY state and no parity_err port; 8N1 only.

Test Plan:
- Send 0x55 with clkdiv_rx=50, o_tready=1 -> o_tvalid pulses for 1 cycle with o_tdata=0x55, 1 cycle after the stop-bit mid-sample (about 478 cycles after the start edge on rx).
- Send 16 back-to-back bytes (0x55,0x55,0x55,0x00,0xAA,0xFF,0x53,0xCA,0x5A,0xA5,0x55,0x55,0x00,0xAA,0xFF,0x53) with o_tready=1 -> identical sequence on AXIS; frame_err and overflow never asserted.
- 10-cycle low glitch on idle rx -> FSM returns to IDLE from START; no o_tvalid, no frame_err.
- Frame with the stop bit driven low, then the line held low for 2000 cycles -> exactly one frame_err pulse; FIFO stays empty; the next valid byte 0xA5 is received correctly.
- RX_SIZE=4, o_tready=0, send 17 bytes 0x00..0x10 -> overflow pulses once on the 17th byte; after setting o_tready=1, bytes 0x00..0x0F drain in order and o_tvalid then drops.
- Assert RESET_N low midway through byte 0x3C, release it, then send 0xC3 -> all outputs 0 during reset; only 0xC3 is delivered.

Source files
------------

// File: rtl/axis_uart_rx_wrapper.sv
// Purpose : UART receiver, 8N1 serial line in, AXI-Stream bytes out, via a 2^RX_SIZE byte FIFO.
// Latency : stop-bit mid-sample to o_tvalid is 1 cycle (plus 2 cycles of input synchroniser).
// Backpr. : o_tready stalls only the FIFO head; a byte arriving while full is dropped and pulses overflow.
//
// Ports:
//   CLOCK, RESET_N    system clock (rising edge), asynchronous active-low reset
//   rx                serial input, asynchronous to CLOCK, idles high
//   o_tdata/o_tvalid  FIFO head byte / FIFO not empty
//   o_tready          consumer ready
//   frame_err         one-cycle pulse: stop bit sampled low
//   overflow          one-cycle pulse: received byte dropped because FIFO was full
//   parity_err        (only with UART_RX_PARITY_EN) one-cycle pulse: even-parity mismatch
// Optional build macro: UART_RX_PARITY_EN selects 8E1 framing with a PARITY state.
module axis_uart_rx_wrapper #(
    parameter int RX_SIZE   = 4,
    parameter int clkdiv_rx = 50
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       rx,
    output logic [7:0] o_tdata,
    output logic       o_tvalid,
    input  logic       o_tready,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overflow
);

    localparam int CW    = $clog2(clkdiv_rx);
    localparam int DEPTH = 1 << RX_SIZE;
    localparam logic [CW-1:0] CNT_HALF = CW'(clkdiv_rx / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(clkdiv_rx - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    // Input synchroniser: both flops reset high so a reset never looks like a start edge.
    logic rx_m, rx_s;
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          push, ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic          par_bit, par_nxt, perr_nxt;
`endif

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        push      = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_bit;
        perr_nxt  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_nxt   = CNT_HALF;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (!rx_s) begin
                    cnt_nxt   = CNT_FULL;
                    bit_nxt   = 3'd0;
                    state_nxt = S_DATA;
                end else begin
                    // Line went back high before mid-start-bit: treat as a glitch.
                    state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    shreg_nxt = {rx_s, shreg[7:1]};
                    cnt_nxt   = CNT_FULL;
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    par_nxt   = rx_s;
                    cnt_nxt   = CNT_FULL;
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                    if ((^shreg) == par_bit) push = 1'b1;
                    else                     perr_nxt = 1'b1;
`else
                    push = 1'b1;
`endif
                    state_nxt = S_IDLE;
                end else begin
                    // Low stop bit wins over any parity result.
                    ferr_nxt  = 1'b1;
                    state_nxt = S_BREAK;
                end
            end
            S_BREAK: begin
                // Held-low line: wait for idle so a break gives exactly one frame_err.
                if (rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte FIFO: one extra pointer bit distinguishes full from empty.
    logic [RX_SIZE:0] wr_ptr, rd_ptr;
    logic [7:0]       mem [DEPTH];
    logic             full, empty, wr_en, rd_en, ovf_nxt;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[RX_SIZE] != rd_ptr[RX_SIZE]) &&
                     (wr_ptr[RX_SIZE-1:0] == rd_ptr[RX_SIZE-1:0]);
    assign o_tvalid = !empty;
    assign rd_en   = o_tvalid && o_tready;
    // A simultaneous read frees the slot, so a write into a full FIFO still succeeds.
    assign wr_en   = push && (!full || rd_en);
    assign ovf_nxt = push && full && !rd_en;
    // Head is gated so the bus reads zero while empty (including during reset).
    assign o_tdata = o_tvalid ? mem[rd_ptr[RX_SIZE-1:0]] : 8'h00;

    always_ff @(posedge CLOCK) begin
        if (wr_en) mem[wr_ptr[RX_SIZE-1:0]] <= shreg;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            frame_err  <= ferr_nxt;
            overflow   <= ovf_nxt;
`ifdef UART_RX_PARITY_EN
            parity_err <= perr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_axis_uart_rx_wrapper.sv
module tb_axis_uart_rx_wrapper;

    localparam int DIV = 50;

    logic       CLOCK    = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       rx       = 1'b1;
    logic       o_tready = 1'b0;
    logic [7:0] o_tdata;
    logic       o_tvalid;
    logic       frame_err;
    logic       overflow;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    axis_uart_rx_wrapper #(.RX_SIZE(4), .clkdiv_rx(DIV)) dut (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .rx        (rx),
        .o_tdata   (o_tdata),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overflow  (overflow)
    );

    always #5 CLOCK = ~CLOCK;

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    logic [7:0] rx_log [256];
    int   rx_wr      = 0;
    int   ferr_tot   = 0;
    int   ovf_tot    = 0;
    int   vld_cycles = 0;
    int   rise_cyc   = 0;
    logic vld_prev   = 1'b0;

    always @(negedge CLOCK) begin
        if (RESET_N) begin
            if (o_tvalid && o_tready) begin
                rx_log[rx_wr[7:0]] = o_tdata;
                rx_wr++;
            end
            if (frame_err) ferr_tot++;
            if (overflow)  ovf_tot++;
            if (o_tvalid)  vld_cycles++;
            if (o_tvalid && !vld_prev) rise_cyc = cyc;
        end
        vld_prev = o_tvalid;
    end

    int vec_cnt = 0;
    int mis_cnt = 0;
    int rx_rd   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (DIV) @(posedge CLOCK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic expect_byte(input string name, input logic [7:0] exp);
        check({name, " avail"}, 32'(rx_wr > rx_rd), 32'd1);
        if (rx_wr > rx_rd) begin
            check({name, " data"}, 32'(rx_log[rx_rd[7:0]]), 32'(exp));
            rx_rd++;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " tdata"},     32'(o_tdata),   32'h00);
        check({name, " tvalid"},    32'(o_tvalid),  32'd0);
        check({name, " frame_err"}, 32'(frame_err), 32'd0);
        check({name, " overflow"},  32'(overflow),  32'd0);
    endtask

    typedef struct {
        logic [7:0] tx_byte;
        logic       stop_bit;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, v0, f0, o0, w0, d;

        tbl[0]  = '{8'h55, 1'b1, 8'h55};  tbl[1]  = '{8'h55, 1'b1, 8'h55};
        tbl[2]  = '{8'h55, 1'b1, 8'h55};  tbl[3]  = '{8'h00, 1'b1, 8'h00};
        tbl[4]  = '{8'hAA, 1'b1, 8'hAA};  tbl[5]  = '{8'hFF, 1'b1, 8'hFF};
        tbl[6]  = '{8'h53, 1'b1, 8'h53};  tbl[7]  = '{8'hCA, 1'b1, 8'hCA};
        tbl[8]  = '{8'h5A, 1'b1, 8'h5A};  tbl[9]  = '{8'hA5, 1'b1, 8'hA5};
        tbl[10] = '{8'h55, 1'b1, 8'h55};  tbl[11] = '{8'h55, 1'b1, 8'h55};
        tbl[12] = '{8'h00, 1'b1, 8'h00};  tbl[13] = '{8'hAA, 1'b1, 8'hAA};
        tbl[14] = '{8'hFF, 1'b1, 8'hFF};  tbl[15] = '{8'h53, 1'b1, 8'h53};

        // Reset state
        repeat (5) @(posedge CLOCK);
        @(negedge CLOCK);
        check_reset_outputs("reset");
        @(posedge CLOCK); #1;
        RESET_N = 1'b1;
        idle(20);

        // Single byte: latency and one-cycle valid pulse with tready high
        o_tready = 1'b1;
        t0 = cyc;
        v0 = vld_cycles;
        send_byte(8'h55, 1'b1);
        idle(20);
        d = rise_cyc - t0;
        check("latency 476..480", 32'(d >= 476 && d <= 480), 32'd1);
        check("valid pulse width", 32'(vld_cycles - v0), 32'd1);
        check("single count", 32'(rx_wr - rx_rd), 32'd1);
        expect_byte("single 0x55", 8'h55);

        // Back-to-back table
        for (int i = 0; i < 16; i++) begin
            send_byte(tbl[i].tx_byte, tbl[i].stop_bit);
            expect_byte($sformatf("b2b[%0d]", i), tbl[i].exp_byte);
        end
        idle(20);
        check("b2b frame_err", 32'(ferr_tot), 32'd0);
        check("b2b overflow", 32'(ovf_tot), 32'd0);

        // Short glitch on idle line
        f0 = ferr_tot;
        w0 = rx_wr;
        rx = 1'b0;
        repeat (10) @(posedge CLOCK);
        #1;
        idle(600);
        check("glitch no byte", 32'(rx_wr - w0), 32'd0);
        check("glitch no frame_err", 32'(ferr_tot - f0), 32'd0);
        check("glitch tvalid", 32'(o_tvalid), 32'd0);

        // Low stop bit followed by a long break, then a good byte
        f0 = ferr_tot;
        w0 = rx_wr;
        send_byte(8'h12, 1'b0);
        rx = 1'b0;
        repeat (2000) @(posedge CLOCK);
        #1;
        idle(100);
        check("break one frame_err", 32'(ferr_tot - f0), 32'd1);
        check("break no byte", 32'(rx_wr - w0), 32'd0);
        check("break tvalid", 32'(o_tvalid), 32'd0);
        send_byte(8'hA5, 1'b1);
        idle(10);
        expect_byte("after break 0xA5", 8'hA5);

        // Overflow: 17 bytes with tready low
        o_tready = 1'b0;
        o0 = ovf_tot;
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i), 1'b1);
            if (i == 15) begin
                idle(5);
                check("full no overflow", 32'(ovf_tot - o0), 32'd0);
                check("full tvalid", 32'(o_tvalid), 32'd1);
                check("full head", 32'(o_tdata), 32'h00);
            end
        end
        idle(5);
        check("overflow once", 32'(ovf_tot - o0), 32'd1);
        check("overflow head kept", 32'(o_tdata), 32'h00);
        check("stalled no handshake", 32'(rx_wr - rx_rd), 32'd0);
        o_tready = 1'b1;
        idle(40);
        check("drain count", 32'(rx_wr - rx_rd), 32'd16);
        for (int i = 0; i < 16; i++) expect_byte($sformatf("drain[%0d]", i), 8'(i));
        check("drain tvalid low", 32'(o_tvalid), 32'd0);

        // Reset in the middle of 0x3C (start + bits 0..3 sent, inside bit 4)
        w0 = rx_wr;
        bit_time(1'b0);
        bit_time(1'b0);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b1);
        rx = 1'b1;
        repeat (20) @(posedge CLOCK);
        #1;
        RESET_N = 1'b0;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        check_reset_outputs("midframe reset");
        @(posedge CLOCK); #1;
        RESET_N = 1'b1;
        idle(600);
        check("after reset no byte", 32'(rx_wr - w0), 32'd0);
        send_byte(8'hC3, 1'b1);
        idle(10);
        check("after reset count", 32'(rx_wr - w0), 32'd1);
        expect_byte("after reset 0xC3", 8'hC3);
        check("final frame_err total", 32'(ferr_tot), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
